mult_mac_pipe: RTL and testbench



---
 rtl/mult_mac_pipe.sv | 125 ++++++++++++
 tb/tb_mult_mac_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_mac_pipe.sv
// Pipelined multiply-accumulate with per-beat signedness, configurable depth,
// a running accumulator with overflow flag, and valid/ready flow control.
module mult_mac_pipe #(
  parameter int WIDTH_A = 18,
  parameter int WIDTH_B = 18,
  parameter int STAGES  = 3,
  parameter int ACC_W   = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic               acc_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_p,
  output logic               out_ovf
);

  localparam int PW = WIDTH_A + WIDTH_B;

  // Handshake: a beat moves on a clock edge where valid && ready are both high.
  // The whole pipe shifts as one unit whenever the output register is empty or
  // being drained, so in_ready is simply that shift condition.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic signed [WIDTH_A:0] a_x;
  logic signed [WIDTH_B:0] b_x;
  logic signed [PW-1:0]    prod;
  logic                    rs_in;
  logic                    v_in;

  assign a_x   = {a_signed & a[WIDTH_A-1], a};
  assign b_x   = {b_signed & b[WIDTH_B-1], b};
  assign prod  = a_x * b_x;
  assign rs_in = a_signed | b_signed;
  assign v_in  = in_valid && in_ready;

  logic [PW-1:0] p_t;
  logic          rs_t;
  logic          en_t;
  logic          v_t;

  generate
    if (STAGES > 1) begin : g_pipe
      logic [PW-1:0] p_q  [STAGES-1];
      logic          rs_q [STAGES-1];
      logic          en_q [STAGES-1];
      logic          v_q  [STAGES-1];

      // Product and its side-band travel together; retiming spreads the multiply.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES-1; i++) begin
            p_q[i]  <= '0;
            rs_q[i] <= 1'b0;
            en_q[i] <= 1'b0;
            v_q[i]  <= 1'b0;
          end
        end else if (advance) begin
          p_q[0]  <= prod;
          rs_q[0] <= rs_in;
          en_q[0] <= acc_en;
          v_q[0]  <= v_in;
          for (int i = 1; i < STAGES-1; i++) begin
            p_q[i]  <= p_q[i-1];
            rs_q[i] <= rs_q[i-1];
            en_q[i] <= en_q[i-1];
            v_q[i]  <= v_q[i-1];
          end
        end
      end

      assign p_t  = p_q[STAGES-2];
      assign rs_t = rs_q[STAGES-2];
      assign en_t = en_q[STAGES-2];
      assign v_t  = v_q[STAGES-2];
    end else begin : g_comb
      assign p_t  = prod;
      assign rs_t = rs_in;
      assign en_t = acc_en;
      assign v_t  = v_in;
    end
  endgenerate

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W:0]   sum;
  logic             ovf_s;
  logic             ovf_u;

  assign p_ext = rs_t ? ACC_W'($signed(p_t)) : ACC_W'(p_t);
  assign sum   = {1'b0, acc} + {1'b0, p_ext};
  assign ovf_s = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  assign ovf_u = sum[ACC_W];

  // The accumulator is the output register; bubbles leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      acc       <= '0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= v_t;
      if (v_t) begin
        if (en_t) begin
          acc     <= sum[ACC_W-1:0];
          out_ovf <= rs_t ? ovf_s : ovf_u;
        end else begin
          acc     <= p_ext;
          out_ovf <= 1'b0;
        end
      end
    end
  end

  assign out_p = acc;

endmodule

// File: tb/tb_mult_mac_pipe.sv
// Directed bench for mult_mac_pipe: a 48-bit and a 36-bit accumulator instance
// share stimulus and are checked every cycle against an arithmetic model.
module tb_mult_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [17:0] a;
  logic [17:0] b;
  logic        a_signed;
  logic        b_signed;
  logic        acc_en;
  logic        out_ready;

  logic        ir48, ov48, ovf48;
  logic [47:0] p48;
  logic        ir36, ov36, ovf36;
  logic [35:0] p36;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [48:0] exp48_q[$];
  logic [36:0] exp36_q[$];
  logic [48:0] got48_q[$];
  logic [36:0] got36_q[$];
  int          got_cyc_q[$];
  longint      macc48 = 0;
  longint      macc36 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mult_mac_pipe u_dut48 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir48),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .acc_en(acc_en),
    .out_valid(ov48), .out_ready(out_ready), .out_p(p48), .out_ovf(ovf48)
  );

  mult_mac_pipe #(.ACC_W(36)) u_dut36 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir36),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .acc_en(acc_en),
    .out_valid(ov36), .out_ready(out_ready), .out_p(p36), .out_ovf(ovf36)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Plain integer arithmetic: real product, then range tests for overflow.
  function automatic logic [48:0] model_beat(input int w, input longint acc,
      input logic [17:0] ma, input logic [17:0] mb,
      input logic mas, input logic mbs, input logic men);
    longint one, av, bv, e, mask, half, sa, se, s;
    logic   ovf;
    one  = 1;
    av   = (mas && ma[17]) ? longint'(ma) - (one << 18) : longint'(ma);
    bv   = (mbs && mb[17]) ? longint'(mb) - (one << 18) : longint'(mb);
    mask = (one << w) - 1;
    half = one << (w - 1);
    e    = (av * bv) & mask;
    if (!men) begin
      s   = e;
      ovf = 1'b0;
    end else if (mas || mbs) begin
      sa  = (acc >= half) ? acc - (one << w) : acc;
      se  = (e >= half) ? e - (one << w) : e;
      s   = sa + se;
      ovf = (s >= half) || (s < -half);
    end else begin
      s   = acc + e;
      ovf = (s > mask);
    end
    s = s & mask;
    return {ovf, s[47:0]};
  endfunction

  always @(negedge rst_n) begin
    exp48_q.delete();
    exp36_q.delete();
    macc48 = 0;
    macc36 = 0;
  end

  always @(negedge clk) begin
    logic [48:0] r;
    if (rst_n) begin
      if (ov48) begin
        if (exp48_q.size() == 0) check("unexpected_out48", 64'(p48), 64'hDEAD);
        else begin
          check("out48", 64'({ovf48, p48}), 64'(exp48_q[0]));
          if (out_ready) begin
            void'(exp48_q.pop_front());
            got48_q.push_back({ovf48, p48});
            got_cyc_q.push_back(cyc);
          end else check("stall_in_ready48", 64'(ir48), 64'd0);
        end
      end
      if (ov36) begin
        if (exp36_q.size() == 0) check("unexpected_out36", 64'(p36), 64'hDEAD);
        else begin
          check("out36", 64'({ovf36, p36}), 64'(exp36_q[0]));
          if (out_ready) begin
            void'(exp36_q.pop_front());
            got36_q.push_back({ovf36, p36});
          end else check("stall_in_ready36", 64'(ir36), 64'd0);
        end
      end
      if (in_valid && ir48) begin
        r = model_beat(48, macc48, a, b, a_signed, b_signed, acc_en);
        macc48 = longint'(r[47:0]);
        exp48_q.push_back(r);
      end
      if (in_valid && ir36) begin
        r = model_beat(36, macc36, a, b, a_signed, b_signed, acc_en);
        macc36 = longint'(r[35:0]);
        exp36_q.push_back({r[48], r[35:0]});
      end
    end
  end

  // Entered and left at posedge+1; holds the beat until it is accepted.
  task automatic send(input logic [17:0] va, input logic [17:0] vb,
      input logic vas, input logic vbs, input logic ven);
    logic taken;
    in_valid = 1'b1; a = va; b = vb; a_signed = vas; b_signed = vbs; acc_en = ven;
    taken = 1'b0;
    for (int i = 0; i < 40 && !taken; i++) begin
      @(negedge clk);
      taken = ir48;
      @(posedge clk);
      #1;
    end
    if (!taken) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a = $urandom_range(0, 18'h3FFFF);
    b = $urandom_range(0, 18'h3FFFF);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp48_q.size() != 0 || exp36_q.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(exp48_q.size() + exp36_q.size()), 64'd0);
  endtask

  task automatic clear_got();
    got48_q.delete();
    got36_q.delete();
    got_cyc_q.delete();
  endtask

  initial begin
    int n;
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    a_signed = 1'b0; b_signed = 1'b0; acc_en = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(ov48), 64'd0);
    check("rst_out_p", 64'(p48), 64'd0);
    check("rst_out_ovf", 64'(ovf48), 64'd0);
    check("rst_in_ready", 64'(ir48), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // -3 * 5 signed, with latency measured from the accept cycle
    clear_got();
    in_valid = 1'b1; a = 18'h3FFFD; b = 18'd5; a_signed = 1'b1; b_signed = 1'b1; acc_en = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) idle();
      if (ov48) break;
    end
    check("latency", 64'(n), 64'd3);
    drain();
    check("signed_m3x5", 64'(got48_q[0]), {15'd0, 1'b0, 48'hFFFF_FFFF_FFF1});

    // Operand extremes, back-to-back
    clear_got();
    send(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b0);
    send(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0, 1'b0);
    send(18'h20000, 18'h20000, 1'b1, 1'b1, 1'b0);
    idle();
    drain();
    check("unsigned_max", 64'(got48_q[0]), {16'd0, 48'h000F_FFF8_0001});
    check("mixed_sign", 64'(got48_q[1]), {16'd0, 48'hFFFF_FFFC_0001});
    check("min_x_min", 64'(got48_q[2]), {16'd0, 48'h0004_0000_0000});

    // Accumulate chain at full throughput
    clear_got();
    send(18'd2, 18'd3, 1'b0, 1'b0, 1'b0);
    send(18'd4, 18'd5, 1'b0, 1'b0, 1'b1);
    send(18'd1, 18'd1, 1'b0, 1'b0, 1'b1);
    send(18'd7, 18'd7, 1'b0, 1'b0, 1'b0);
    idle();
    drain();
    check("acc_seq0", 64'(got48_q[0]), 64'd6);
    check("acc_seq1", 64'(got48_q[1]), 64'd26);
    check("acc_seq2", 64'(got48_q[2]), 64'd27);
    check("acc_seq3", 64'(got48_q[3]), 64'd49);
    for (int i = 0; i < 3; i++)
      check("acc_consecutive", 64'(got_cyc_q[i+1] - got_cyc_q[i]), 64'd1);

    // Signed overflow on the 36-bit accumulator
    clear_got();
    send(18'h20000, 18'h20000, 1'b1, 1'b1, 1'b0);
    send(18'h20000, 18'h20000, 1'b1, 1'b1, 1'b1);
    idle();
    drain();
    check("ovf36_first", 64'(got36_q[0]), {28'd0, 1'b0, 36'h4_0000_0000});
    check("ovf36_second", 64'(got36_q[1]), {28'd0, 1'b1, 36'h8_0000_0000});
    check("no_ovf48", 64'(got48_q[1]), {16'd0, 48'h0008_0000_0000});

    // Backpressure with three beats in flight
    clear_got();
    out_ready = 1'b0;
    send(18'd1, 18'd1, 1'b0, 1'b0, 1'b0);
    send(18'd2, 18'd2, 1'b0, 1'b0, 1'b1);
    send(18'd3, 18'd3, 1'b0, 1'b0, 1'b1);
    idle();
    repeat (4) @(posedge clk);
    #1;
    check("stall_held_valid", 64'(ov48), 64'd1);
    out_ready = 1'b1;
    drain();
    check("bp_count", 64'(got48_q.size()), 64'd3);
    check("bp_seq0", 64'(got48_q[0]), 64'd1);
    check("bp_seq1", 64'(got48_q[1]), 64'd5);
    check("bp_seq2", 64'(got48_q[2]), 64'd14);

    // Asynchronous reset while beats are in flight
    clear_got();
    send(18'd9, 18'd9, 1'b0, 1'b0, 1'b0);
    send(18'd8, 18'd8, 1'b0, 1'b0, 1'b1);
    send(18'd7, 18'd7, 1'b0, 1'b0, 1'b1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid48", 64'(ov48), 64'd0);
    check("midrst_p48", 64'(p48), 64'd0);
    check("midrst_valid36", 64'(ov36), 64'd0);
    check("midrst_p36", 64'(p36), 64'd0);
    n = got48_q.size();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("no_stale_out", 64'(got48_q.size()), 64'(n));

    // Fresh load after reset starts from an empty accumulator
    clear_got();
    send(18'd6, 18'd7, 1'b0, 1'b0, 1'b1);
    idle();
    drain();
    check("post_rst_acc", 64'(got48_q[0]), 64'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
